// File: rtl/pulse_sequencer_if.sv
// UART byte stream in, generator settings/trigger and burst status out.
// master drives the receive side; slave is the sequencer.
interface pulse_sequencer_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [20:0] pulse_width1;
    logic [20:0] pulse_width2;
    logic [20:0] pulse_gap;
    logic        trig_out;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  fire_cnt;

    modport master (
        output rx_data, rx_valid,
        input  pulse_width1, pulse_width2, pulse_gap,
        input  trig_out, busy, done, err, fire_cnt
    );

    modport slave (
        input  rx_data, rx_valid,
        output pulse_width1, pulse_width2, pulse_gap,
        output trig_out, busy, done, err, fire_cnt
    );
endinterface

// File: rtl/pulse_sequencer.sv
// Framed UART command parser plus burst trigger scheduler
// for the double-pulse generator.
module pulse_sequencer #(
    parameter int unsigned TRIG_LEN   = 4,
    parameter int unsigned TIMEOUT    = 500_000,
    parameter logic [20:0] DEF_W1     = 21'd999,
    parameter logic [20:0] DEF_W2     = 21'd999,
    parameter logic [20:0] DEF_GAP    = 21'd1999,
    parameter logic [23:0] DEF_PERIOD = 24'd5_000_000,
    parameter logic [23:0] MIN_PERIOD = 24'd100
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    pulse_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        P_IDLE, P_OP, P_D2, P_D1, P_D0, P_CHK
    } p_state_t;

    typedef enum logic [1:0] {
        S_IDLE, S_FIRE, S_WAIT
    } s_state_t;

    localparam logic [23:0] TO_LAST = 24'(TIMEOUT - 1);
    localparam logic [7:0]  TL_LAST = 8'(TRIG_LEN - 1);

    p_state_t    p_state_q;
    logic [7:0]  op_q, d2_q, d1_q, d0_q, sum_q;
    logic [23:0] gap_cnt_q;

    logic [20:0] w1_q, w2_q, gap_q;
    logic [23:0] period_q;
    logic [7:0]  count_q;

    s_state_t    s_state_q;
    logic [23:0] per_cnt_q;
    logic [7:0]  tl_cnt_q;
    logic [7:0]  fire_cnt_q;
    logic        trig_q, busy_q, done_q, err_q;

    logic        rx_v;
    logic [7:0]  rx_b;
    logic [23:0] data_w;
    logic        timeout, frame_ok, chk_bad;
    logic        op_wr, op_start, op_stop;
    logic        exec_wr, do_start, do_stop, cmd_err;
    logic        per_last, burst_end;

    assign rx_v   = bus.rx_valid;
    assign rx_b   = bus.rx_data;
    assign data_w = {d2_q, d1_q, d0_q};

    assign timeout  = (p_state_q != P_IDLE) && !rx_v
                    && (gap_cnt_q == TO_LAST);
    assign frame_ok = (p_state_q == P_CHK) && rx_v
                    && (rx_b == sum_q);
    assign chk_bad  = (p_state_q == P_CHK) && rx_v
                    && (rx_b != sum_q);

    always_comb begin
        op_wr    = 1'b0;
        op_start = 1'b0;
        op_stop  = 1'b0;
        unique case (1'b1)
            (op_q >= 8'h01 && op_q <= 8'h05): op_wr    = 1'b1;
            (op_q == 8'h10):                  op_start = 1'b1;
            (op_q == 8'h11):                  op_stop  = 1'b1;
            default: ;
        endcase
    end

    // Only stop is honoured mid-burst; everything else is refused.
    assign exec_wr  = frame_ok && op_wr && !busy_q;
    assign do_start = frame_ok && op_start && !busy_q;
    assign do_stop  = frame_ok && op_stop && busy_q;
    assign cmd_err  = frame_ok && (busy_q ? !op_stop
                    : !(op_wr || op_start || op_stop));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            p_state_q <= P_IDLE;
            op_q      <= 8'd0;
            d2_q      <= 8'd0;
            d1_q      <= 8'd0;
            d0_q      <= 8'd0;
            sum_q     <= 8'd0;
            gap_cnt_q <= 24'd0;
        end else begin
            if (rx_v || p_state_q == P_IDLE) gap_cnt_q <= 24'd0;
            else                             gap_cnt_q <= gap_cnt_q + 24'd1;

            if (timeout) begin
                p_state_q <= P_IDLE;
            end else if (rx_v) begin
                case (p_state_q)
                    P_IDLE: if (rx_b == 8'h55) p_state_q <= P_OP;
                    P_OP: begin
                        op_q      <= rx_b;
                        sum_q     <= rx_b;
                        p_state_q <= P_D2;
                    end
                    P_D2: begin
                        d2_q      <= rx_b;
                        sum_q     <= sum_q + rx_b;
                        p_state_q <= P_D1;
                    end
                    P_D1: begin
                        d1_q      <= rx_b;
                        sum_q     <= sum_q + rx_b;
                        p_state_q <= P_D0;
                    end
                    P_D0: begin
                        d0_q      <= rx_b;
                        sum_q     <= sum_q + rx_b;
                        p_state_q <= P_CHK;
                    end
                    default: p_state_q <= P_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            w1_q     <= DEF_W1;
            w2_q     <= DEF_W2;
            gap_q    <= DEF_GAP;
            period_q <= DEF_PERIOD;
            count_q  <= 8'd1;
            err_q    <= 1'b0;
        end else begin
            err_q <= timeout | chk_bad | cmd_err;
            if (exec_wr) begin
                case (op_q)
                    8'h01: w1_q  <= data_w[20:0];
                    8'h02: w2_q  <= data_w[20:0];
                    8'h03: gap_q <= data_w[20:0];
                    8'h04: period_q <= (data_w < MIN_PERIOD)
                                     ? MIN_PERIOD : data_w;
                    default: count_q <= d0_q;
                endcase
            end
        end
    end

    assign per_last  = (per_cnt_q == period_q - 24'd1);
    assign burst_end = (count_q != 8'd0) && (fire_cnt_q == count_q);

    // Period counter starts at 0 on every S_FIRE entry, so edges are period apart.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s_state_q  <= S_IDLE;
            per_cnt_q  <= 24'd0;
            tl_cnt_q   <= 8'd0;
            fire_cnt_q <= 8'd0;
            trig_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (do_stop) begin
                s_state_q <= S_IDLE;
                trig_q    <= 1'b0;
                busy_q    <= 1'b0;
                done_q    <= 1'b1;
            end else begin
                case (s_state_q)
                    S_IDLE: if (do_start) begin
                        s_state_q  <= S_FIRE;
                        busy_q     <= 1'b1;
                        trig_q     <= 1'b1;
                        fire_cnt_q <= 8'd1;
                        per_cnt_q  <= 24'd0;
                        tl_cnt_q   <= 8'd0;
                    end
                    S_FIRE: begin
                        per_cnt_q <= per_cnt_q + 24'd1;
                        tl_cnt_q  <= tl_cnt_q + 8'd1;
                        if (tl_cnt_q == TL_LAST) begin
                            trig_q    <= 1'b0;
                            s_state_q <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (!per_last) begin
                            per_cnt_q <= per_cnt_q + 24'd1;
                        end else if (burst_end) begin
                            s_state_q <= S_IDLE;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            s_state_q  <= S_FIRE;
                            trig_q     <= 1'b1;
                            fire_cnt_q <= fire_cnt_q + 8'd1;
                            per_cnt_q  <= 24'd0;
                            tl_cnt_q   <= 8'd0;
                        end
                    end
                    default: s_state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.pulse_width1 = w1_q;
    assign bus.pulse_width2 = w2_q;
    assign bus.pulse_gap    = gap_q;
    assign bus.trig_out     = trig_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign bus.fire_cnt     = fire_cnt_q;
endmodule
